// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap MAC engine: default sizes, FSM encoding
// and the accumulator-to-output saturation helper.
package fir_pkg;

   localparam int NTAPS_D  = 16;
   localparam int DW_D     = 8;
   localparam int ACCW_D   = 24;
   localparam int OUTW_D   = 16;
   localparam int OSHIFT_D = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } fir_state_t;

   // Arithmetic shift (floor toward -inf) then clamp into the signed output range.
   function automatic logic signed [OUTW_D-1:0] sat_acc(input logic signed [ACCW_D-1:0] acc,
                                                        input int unsigned oshift);
      logic signed [ACCW_D-1:0] s;
      logic signed [ACCW_D-1:0] smax;
      logic signed [ACCW_D-1:0] smin;
      smax = {{(ACCW_D-OUTW_D+1){1'b0}}, {(OUTW_D-1){1'b1}}};
      smin = {{(ACCW_D-OUTW_D+1){1'b1}}, {(OUTW_D-1){1'b0}}};
      s    = acc >>> oshift;
      if (s > smax) begin
         return smax[OUTW_D-1:0];
      end else if (s < smin) begin
         return smin[OUTW_D-1:0];
      end else begin
         return s[OUTW_D-1:0];
      end
   endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: written only while the engine is idle so a filter
// pass always sees one consistent coefficient set; read combinationally.
module fir_coef_bank
   import fir_pkg::*;
#(
   parameter int NTAPS = NTAPS_D,
   parameter int DW    = DW_D
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_idle,
   input  logic                       i_we,
   input  logic [$clog2(NTAPS)-1:0]   i_wr_addr,
   input  logic signed [DW-1:0]       i_wr_data,
   input  logic [$clog2(NTAPS)-1:0]   i_rd_addr,
   output logic signed [DW-1:0]       o_rd_data
);

   logic signed [DW-1:0] r_coef [NTAPS];

   // Coefficient storage with idle-gated write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAPS; i++) begin
            r_coef[i] <= {DW{1'b0}};
         end
      end else if (i_idle && i_we) begin
         r_coef[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_coef[i_rd_addr];

endmodule

// File: rtl/signedApproxMult.sv
// Approximate 8x8 signed multiplier: each operand magnitude keeps only its four
// most significant bits, so products of operands below 16 in magnitude are exact.
module signedApproxMult (
   input  logic signed [7:0]  i_a,
   input  logic signed [7:0]  i_b,
   output logic signed [15:0] o_p
);

   function automatic logic [7:0] keep_msb4(input logic [7:0] m);
      logic [7:0] r;
      if (m[7]) begin
         r = m & 8'hF0;
      end else if (m[6]) begin
         r = m & 8'hF8;
      end else if (m[5]) begin
         r = m & 8'hFC;
      end else if (m[4]) begin
         r = m & 8'hFE;
      end else begin
         r = m;
      end
      return r;
   endfunction

   logic [7:0]  w_ma;
   logic [7:0]  w_mb;
   logic [15:0] w_mag;
   logic        w_neg;

   assign w_ma  = i_a[7] ? (8'd0 - $unsigned(i_a)) : $unsigned(i_a);
   assign w_mb  = i_b[7] ? (8'd0 - $unsigned(i_b)) : $unsigned(i_b);
   assign w_neg = i_a[7] ^ i_b[7];
   assign w_mag = {8'd0, keep_msb4(w_ma)} * {8'd0, keep_msb4(w_mb)};
   assign o_p   = w_neg ? $signed(16'd0 - w_mag) : $signed(w_mag);

endmodule

// File: rtl/fir_tap_mac_engine.sv
// Time-multiplexed FIR engine: one sample in, NTAPS MAC cycles through a single
// approximate multiplier, one saturated output out per sample.
module fir_tap_mac_engine
   import fir_pkg::*;
#(
   parameter int NTAPS  = NTAPS_D,
   parameter int DW     = DW_D,
   parameter int ACCW   = ACCW_D,
   parameter int OUTW   = OUTW_D,
   parameter int OSHIFT = OSHIFT_D
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [DW-1:0]       in_data,
   input  logic                       coef_we,
   input  logic [$clog2(NTAPS)-1:0]   coef_addr,
   input  logic signed [DW-1:0]       coef_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [OUTW-1:0]     out_data,
   output logic                       busy
);

   localparam int AW = $clog2(NTAPS);
   localparam logic [AW-1:0] LAST_K = AW'(NTAPS - 1);

   fir_state_t            r_state;
   fir_state_t            w_state_nxt;
   logic signed [DW-1:0]  r_dly [NTAPS];
   logic [AW-1:0]         r_k;
   logic signed [ACCW-1:0] r_acc;
   logic signed [ACCW-1:0] w_acc_nxt;
   logic signed [2*DW-1:0] w_prod;
   logic signed [DW-1:0]  w_coef;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic                  r_busy;
   logic signed [OUTW-1:0] r_out_data;
   logic                  w_accept;
   logic                  w_last;

   assign w_accept  = in_valid & r_in_ready & (r_state == ST_IDLE);
   assign w_last    = (r_k == LAST_K);
   assign w_acc_nxt = r_acc + {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};

   fir_coef_bank #(.NTAPS(NTAPS), .DW(DW)) u_coef_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_idle    (r_state == ST_IDLE),
      .i_we      (coef_we),
      .i_wr_addr (coef_addr),
      .i_wr_data (coef_data),
      .i_rd_addr (r_k),
      .o_rd_data (w_coef)
   );

   signedApproxMult u_mult (
      .i_a (r_dly[r_k]),
      .i_b (w_coef),
      .o_p (w_prod)
   );

   // Next-state decode for the IDLE -> MAC -> OUT -> IDLE sequence
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_MAC;
            else          w_state_nxt = ST_IDLE;
         end
         ST_MAC: begin
            if (w_last) w_state_nxt = ST_OUT;
            else        w_state_nxt = ST_MAC;
         end
         ST_OUT: begin
            if (out_ready) w_state_nxt = ST_IDLE;
            else           w_state_nxt = ST_OUT;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register and registered handshake/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == ST_IDLE);
         r_out_valid <= (w_state_nxt == ST_OUT);
         r_busy      <= (w_state_nxt != ST_IDLE);
      end
   end

   // Delay line, tap counter, accumulator and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAPS; i++) begin
            r_dly[i] <= {DW{1'b0}};
         end
         r_k        <= {AW{1'b0}};
         r_acc      <= {ACCW{1'b0}};
         r_out_data <= {OUTW{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_dly[0] <= in_data;
                  for (int i = 1; i < NTAPS; i++) begin
                     r_dly[i] <= r_dly[i-1];
                  end
                  r_acc <= {ACCW{1'b0}};
                  r_k   <= {AW{1'b0}};
               end
            end
            ST_MAC: begin
               r_acc <= w_acc_nxt;
               r_k   <= r_k + {{(AW-1){1'b0}}, 1'b1};
               // Saturate from the final sum directly so OUT starts the next cycle
               if (w_last) r_out_data <= sat_acc(w_acc_nxt, OSHIFT);
            end
            default: begin
               r_k <= r_k;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;

endmodule
